// File: rtl/pe_accumulator.sv
// Accumulation stage of the systolic PE: aligns valid/first/last tags with the multiplier
// product, sums each sequence and presents the result on a valid/ready port. Define ACC_SAT_EN for saturating sums.
module pe_accumulator #(
  parameter int STAGE     = 0,
  parameter int WIDTH_MUL = 32,
  parameter int WIDTH_ACC = 40,
  parameter bit SIGNED    = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipeline_en,
  output logic                 mul_pipeline_en,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [WIDTH_MUL-1:0] mul_out,
  output logic [WIDTH_ACC-1:0] acc_out,
  output logic                 ovf,
  output logic                 proto_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic {
    ACC_IDLE = 1'b0,
    ACC_RUN  = 1'b1
  } acc_state_e;

  acc_state_e           state_q, state_d;
  logic [WIDTH_ACC-1:0] acc_q, acc_d;
  logic [WIDTH_ACC-1:0] acc_out_q, acc_out_d;
  logic                 run_ovf_q, run_ovf_d;
  logic                 ovf_q, ovf_d;
  logic                 proto_err_q, proto_err_d;
  logic                 out_valid_q, out_valid_d;

  logic                 stall_s, advance_s, load_s;
  logic                 tag_v_s, tag_f_s, tag_l_s;
  logic                 start_s, idle_hit_s;
  logic                 add_ovf_s, step_ovf_s, new_ovf_s;
  logic [WIDTH_ACC-1:0] ext_s, accum_s, new_acc_s;
  logic [WIDTH_ACC:0]   sum_s;

  // Overflow of a + b: carry out when unsigned, same-sign operands with a flipped result sign when signed.
  function automatic logic add_overflow(input logic [WIDTH_ACC-1:0] a,
                                        input logic [WIDTH_ACC-1:0] b,
                                        input logic [WIDTH_ACC:0]   sum);
    logic r;
    if (SIGNED) begin
      r = (a[WIDTH_ACC-1] == b[WIDTH_ACC-1]) && (sum[WIDTH_ACC-1] != a[WIDTH_ACC-1]);
    end else begin
      r = sum[WIDTH_ACC];
    end
    return r;
  endfunction

`ifdef ACC_SAT_EN
  // Saturation limit in the direction of the operand sign (all-ones when unsigned).
  function automatic logic [WIDTH_ACC-1:0] sat_value(input logic neg);
    logic [WIDTH_ACC-1:0] v;
    if (SIGNED) begin
      v                = {WIDTH_ACC{~neg}};
      v[WIDTH_ACC-1]   = neg;
    end else begin
      v = {WIDTH_ACC{1'b1}};
    end
    return v;
  endfunction
`endif

  // A pending result blocks the whole PE until the consumer takes it.
  assign stall_s         = out_valid_q & ~out_ready;
  assign advance_s       = pipeline_en & ~stall_s;
  assign mul_pipeline_en = advance_s;
  assign load_s          = advance_s & tag_v_s;

  generate
    if (STAGE == 0) begin : g_no_tag_pipe
      assign tag_v_s = in_valid;
      assign tag_f_s = in_first;
      assign tag_l_s = in_last;
    end else begin : g_tag_pipe
      logic [STAGE-1:0] valid_q, valid_d;
      logic [STAGE-1:0] first_q, first_d;
      logic [STAGE-1:0] last_q, last_d;

      // Tag delay line: shifts one slot per advance so depth STAGE lines up with mul_out.
      always_comb begin
        valid_d = valid_q;
        first_d = first_q;
        last_d  = last_q;
        if (advance_s) begin
          valid_d[0] = in_valid;
          first_d[0] = in_first;
          last_d[0]  = in_last;
          for (int k = 1; k < STAGE; k++) begin
            valid_d[k] = valid_q[k-1];
            first_d[k] = first_q[k-1];
            last_d[k]  = last_q[k-1];
          end
        end else begin
          valid_d = valid_q;
        end
      end

      // Tag delay-line registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_q <= {STAGE{1'b0}};
          first_q <= {STAGE{1'b0}};
          last_q  <= {STAGE{1'b0}};
        end else begin
          valid_q <= valid_d;
          first_q <= first_d;
          last_q  <= last_d;
        end
      end

      assign tag_v_s = valid_q[STAGE-1];
      assign tag_f_s = first_q[STAGE-1];
      assign tag_l_s = last_q[STAGE-1];
    end
  endgenerate

  // Extend the product to accumulator width, sign-filling only for signed products.
  always_comb begin
    if (SIGNED) begin
      ext_s = {WIDTH_ACC{mul_out[WIDTH_MUL-1]}};
    end else begin
      ext_s = {WIDTH_ACC{1'b0}};
    end
    ext_s[WIDTH_MUL-1:0] = mul_out;
  end

  // Running sum for a continuing sequence; a saturated sum is frozen until the sequence ends.
  always_comb begin
    sum_s      = {1'b0, acc_q} + {1'b0, ext_s};
    add_ovf_s  = add_overflow(acc_q, ext_s, sum_s);
    step_ovf_s = run_ovf_q | add_ovf_s;
`ifdef ACC_SAT_EN
    if (run_ovf_q) begin
      accum_s = acc_q;
    end else if (add_ovf_s) begin
      accum_s = sat_value(acc_q[WIDTH_ACC-1]);
    end else begin
      accum_s = sum_s[WIDTH_ACC-1:0];
    end
`else
    accum_s = sum_s[WIDTH_ACC-1:0];
`endif
  end

  // A non-first product while idle restarts the sum and is flagged as a protocol error.
  always_comb begin
    case (state_q)
      ACC_IDLE: begin
        start_s    = 1'b1;
        idle_hit_s = ~tag_f_s;
      end
      ACC_RUN: begin
        start_s    = tag_f_s;
        idle_hit_s = 1'b0;
      end
      default: begin
        start_s    = 1'b1;
        idle_hit_s = 1'b0;
      end
    endcase
    if (start_s) begin
      new_acc_s = ext_s;
      new_ovf_s = 1'b0;
    end else begin
      new_acc_s = accum_s;
      new_ovf_s = step_ovf_s;
    end
  end

  // Next state: accumulator, sequence state, result register and output handshake.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    run_ovf_d   = run_ovf_q;
    acc_out_d   = acc_out_q;
    ovf_d       = ovf_q;
    proto_err_d = proto_err_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    if (load_s) begin
      acc_d     = new_acc_s;
      run_ovf_d = new_ovf_s;
      if (idle_hit_s) begin
        proto_err_d = 1'b1;
      end else begin
        proto_err_d = proto_err_q;
      end
      if (tag_l_s) begin
        acc_out_d   = new_acc_s;
        ovf_d       = new_ovf_s;
        out_valid_d = 1'b1;
        state_d     = ACC_IDLE;
      end else begin
        state_d = ACC_RUN;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Accumulator, state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC_IDLE;
      acc_q       <= {WIDTH_ACC{1'b0}};
      run_ovf_q   <= 1'b0;
      acc_out_q   <= {WIDTH_ACC{1'b0}};
      ovf_q       <= 1'b0;
      proto_err_q <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      run_ovf_q   <= run_ovf_d;
      acc_out_q   <= acc_out_d;
      ovf_q       <= ovf_d;
      proto_err_q <= proto_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign acc_out   = acc_out_q;
  assign ovf       = ovf_q;
  assign proto_err = proto_err_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pe_accumulator.sv
// Bench for pe_accumulator: an unsigned STAGE=0 / 33-bit instance and a signed STAGE=2 / 40-bit
// instance, both checked every cycle against a sequence-level arithmetic model.
`timescale 1ns/1ps
module tb_pe_accumulator;

`ifdef ACC_SAT_EN
  localparam bit SAT = 1'b1;
  localparam logic [63:0] EXP_OVF_SUM = 64'h1_FFFF_FFFF;
`else
  localparam bit SAT = 1'b0;
  localparam logic [63:0] EXP_OVF_SUM = 64'h0_FFFF_FFFD;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  pe_en, iv, ifst, ilst, ordy;
  logic [31:0] prod [2];
  wire  [1:0]  mpe, ovf_o, perr_o, ov_o;
  wire  [32:0] acc_a;
  wire  [39:0] acc_b;
  logic [31:0] mp1 = 32'd0;
  logic [31:0] mp2 = 32'd0;

  always #5 clk = ~clk;

  // Two-stage multiplier stand-in for the signed instance, advancing on its enable.
  always @(posedge clk) begin
    if (mpe[1]) begin
      mp1 <= prod[1];
      mp2 <= mp1;
    end
  end

  pe_accumulator #(.STAGE(0), .WIDTH_MUL(32), .WIDTH_ACC(33), .SIGNED(1'b0)) u_unsigned (
    .clk(clk), .rst(rst), .pipeline_en(pe_en[0]), .mul_pipeline_en(mpe[0]),
    .in_valid(iv[0]), .in_first(ifst[0]), .in_last(ilst[0]), .mul_out(prod[0]),
    .acc_out(acc_a), .ovf(ovf_o[0]), .proto_err(perr_o[0]), .out_valid(ov_o[0]),
    .out_ready(ordy[0]));

  pe_accumulator #(.STAGE(2), .WIDTH_MUL(32), .WIDTH_ACC(40), .SIGNED(1'b1)) u_signed (
    .clk(clk), .rst(rst), .pipeline_en(pe_en[1]), .mul_pipeline_en(mpe[1]),
    .in_valid(iv[1]), .in_first(ifst[1]), .in_last(ilst[1]), .mul_out(mp2),
    .acc_out(acc_b), .ovf(ovf_o[1]), .proto_err(perr_o[1]), .out_valid(ov_o[1]),
    .out_ready(ordy[1]));

  typedef struct {
    bit          v;
    bit          f;
    bit          l;
    logic [31:0] p;
  } item_t;

  // Reference model: products wait for STAGE further advances, then are summed as integers.
  item_t  q0[$];
  item_t  q1[$];
  int     stg  [2] = '{0, 2};
  int     wacc [2] = '{33, 40};
  bit     sgn  [2] = '{1'b0, 1'b1};
  longint m_acc [2];
  longint m_res [2];
  bit     m_run [2];
  bit     m_rovf [2];
  bit     m_ovf [2];
  bit     m_ov [2];
  bit     m_perr [2];
  bit     last_adv [2];
  int     n_checks = 0;
  int     n_errors = 0;

  logic [31:0] vals [4];
  longint      ref_sum;
  bit          pat [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  int          idx;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic longint mask_of(int i);
    longint one = 64'sd1;
    return (one <<< wacc[i]) - one;
  endfunction

  function automatic void process(int i, item_t it);
    longint one = 64'sd1;
    longint hi, lo, e, s;
    bit     start;
    if (!it.v) return;
    if (sgn[i]) begin
      hi = (one <<< (wacc[i] - 1)) - one;
      lo = -(one <<< (wacc[i] - 1));
      e  = longint'($signed(it.p));
    end else begin
      hi = mask_of(i);
      lo = 0;
      e  = longint'({32'd0, it.p});
    end
    start = it.f || !m_run[i];
    if (!it.f && !m_run[i]) m_perr[i] = 1'b1;
    if (start) begin
      m_acc[i]  = e;
      m_rovf[i] = 1'b0;
    end else if (!(SAT && m_rovf[i])) begin
      s = m_acc[i] + e;
      if (s > hi || s < lo) begin
        m_rovf[i] = 1'b1;
        if (SAT) begin
          s = (s > hi) ? hi : lo;
        end else begin
          s = s & mask_of(i);
          if (sgn[i] && s > hi) s = s - (one <<< wacc[i]);
        end
      end
      m_acc[i] = s;
    end
    if (it.l) begin
      m_res[i] = m_acc[i];
      m_ovf[i] = m_rovf[i];
      m_ov[i]  = 1'b1;
      m_run[i] = 1'b0;
    end else begin
      m_run[i] = 1'b1;
    end
  endfunction

  function automatic void step_model(int i);
    item_t it;
    if (m_ov[i] && ordy[i]) m_ov[i] = 1'b0;
    if (last_adv[i]) begin
      it.v = iv[i];
      it.f = ifst[i];
      it.l = ilst[i];
      it.p = prod[i];
      if (i == 0) begin
        q0.push_back(it);
        if (q0.size() > stg[0]) process(0, q0.pop_front());
      end else begin
        q1.push_back(it);
        if (q1.size() > stg[1]) process(1, q1.pop_front());
      end
    end
  endfunction

  function automatic void model_clear();
    q0.delete();
    q1.delete();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0; m_res[i] = 0; m_run[i] = 1'b0; m_rovf[i] = 1'b0;
      m_ovf[i] = 1'b0; m_ov[i] = 1'b0; m_perr[i] = 1'b0;
    end
  endfunction

  task automatic check_outputs();
    logic [63:0] got;
    for (int i = 0; i < 2; i++) begin
      got = (i == 0) ? {31'd0, acc_a} : {24'd0, acc_b};
      check($sformatf("acc_out[%0d]", i), got, 64'(m_res[i] & mask_of(i)));
      check($sformatf("out_valid[%0d]", i), {63'd0, ov_o[i]}, {63'd0, m_ov[i]});
      check($sformatf("ovf[%0d]", i), {63'd0, ovf_o[i]}, {63'd0, m_ovf[i]});
      check($sformatf("proto_err[%0d]", i), {63'd0, perr_o[i]}, {63'd0, m_perr[i]});
    end
  endtask

  // One clock: check the enable, advance the model, then check registered outputs after the edge.
  task automatic cycle();
    #1;
    for (int i = 0; i < 2; i++) begin
      last_adv[i] = pe_en[i] && !(m_ov[i] && !ordy[i]);
      check($sformatf("mul_pipeline_en[%0d]", i), {63'd0, mpe[i]}, {63'd0, last_adv[i]});
      step_model(i);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_idle(input int i);
    pe_en[i] = 1'b1; iv[i] = 1'b0; ifst[i] = 1'b0; ilst[i] = 1'b0; ordy[i] = 1'b1;
    prod[i] = 32'd0;
  endtask

  task automatic put(input int i, input bit v, input bit f, input bit l,
                     input logic [31:0] p, input bit rdy);
    pe_en[i] = 1'b1; iv[i] = v; ifst[i] = f; ilst[i] = l; prod[i] = p; ordy[i] = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pe_en[i] = 1'($urandom); iv[i] = 1'($urandom); ifst[i] = 1'($urandom);
      ilst[i] = 1'($urandom); ordy[i] = 1'($urandom); prod[i] = $urandom;
    end
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("rst_mul_pipeline_en[%0d]", i), {63'd0, mpe[i]}, {63'd0, pe_en[i]});
    model_clear();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    set_idle(0);
    set_idle(1);
  endtask

  task automatic wait_valid(input int i);
    for (int k = 0; k < 8 && !ov_o[i]; k++) cycle();
    check($sformatf("result_valid[%0d]", i), {63'd0, ov_o[i]}, 64'd1);
  endtask

  initial begin
    set_idle(0);
    set_idle(1);
    model_clear();
    do_reset();

    // Unsigned 3 + 5 + 7, result held by the consumer.
    put(0, 1'b1, 1'b1, 1'b0, 32'd3, 1'b1); cycle();
    put(0, 1'b1, 1'b0, 1'b0, 32'd5, 1'b1); cycle();
    put(0, 1'b1, 1'b0, 1'b1, 32'd7, 1'b0); cycle();
    check("seq_valid", {63'd0, ov_o[0]}, 64'd1);
    check("seq_sum", {31'd0, acc_a}, 64'd15);
    check("seq_ovf", {63'd0, ovf_o[0]}, 64'd0);

    // Backpressure: the next sequence waits until 15 is accepted.
    for (int k = 0; k < 3; k++) begin
      put(0, 1'b1, 1'b1, 1'b0, 32'd2, 1'b0); cycle();
      check("bp_stall_en", {63'd0, mpe[0]}, 64'd0);
      check("bp_hold_acc", {31'd0, acc_a}, 64'd15);
    end
    put(0, 1'b1, 1'b1, 1'b0, 32'd2, 1'b1); cycle();
    check("bp_accepted", {63'd0, ov_o[0]}, 64'd0);
    put(0, 1'b1, 1'b0, 1'b1, 32'd4, 1'b1); cycle();
    check("bp_second_sum", {31'd0, acc_a}, 64'd6);
    set_idle(0); cycle();

    // 33-bit unsigned overflow.
    put(0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1); cycle();
    put(0, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1); cycle();
    put(0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1); cycle();
    check("ovf_sum", {31'd0, acc_a}, EXP_OVF_SUM);
    check("ovf_flag", {63'd0, ovf_o[0]}, 64'd1);
    set_idle(0); cycle();

    // Signed -4 + 10 through the two-stage pipe.
    put(1, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1); cycle();
    put(1, 1'b1, 1'b0, 1'b1, 32'd10, 1'b1); cycle();
    set_idle(1);
    wait_valid(1);
    check("signed_sum", {24'd0, acc_b}, 64'd6);
    check("signed_ovf", {63'd0, ovf_o[1]}, 64'd0);
    cycle();

    // pipeline_en toggling 1,0,1,1,0,1 with upstream holding operands while not advancing.
    ref_sum = 0;
    for (int k = 0; k < 4; k++) begin
      vals[k] = 32'($urandom_range(0, 2000)) - 32'd1000;
      ref_sum = ref_sum + longint'($signed(vals[k]));
    end
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      pe_en[1] = pat[c]; ordy[1] = 1'b1;
      iv[1] = (idx < 4); ifst[1] = (idx == 0); ilst[1] = (idx == 3);
      prod[1] = (idx < 4) ? vals[idx] : 32'd0;
      cycle();
      if (last_adv[1] && idx < 4) idx++;
    end
    check("toggle_issued", 64'(idx), 64'd4);
    set_idle(1);
    wait_valid(1);
    check("toggle_sum", {24'd0, acc_b}, {24'd0, 40'(ref_sum)});
    cycle();

    // Reset in the middle of a sequence discards it.
    put(1, 1'b1, 1'b1, 1'b0, 32'd100, 1'b1); cycle();
    put(1, 1'b1, 1'b0, 1'b0, 32'd200, 1'b1); cycle();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      cycle();
      check("abort_no_valid", {63'd0, ov_o[1]}, 64'd0);
    end

    // Lone non-first product while idle.
    check("proto_clear", {63'd0, perr_o[1]}, 64'd0);
    put(1, 1'b1, 1'b0, 1'b1, 32'd55, 1'b1); cycle();
    set_idle(1);
    wait_valid(1);
    check("proto_err_set", {63'd0, perr_o[1]}, 64'd1);
    check("proto_sum", {24'd0, acc_b}, 64'd55);
    cycle();

    // Random traffic on both instances, with one reset part-way through.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        pe_en[i] = ($urandom_range(0, 3) != 0);
        iv[i]    = 1'($urandom_range(0, 1));
        ifst[i]  = ($urandom_range(0, 3) == 0);
        ilst[i]  = ($urandom_range(0, 3) == 0);
        ordy[i]  = ($urandom_range(0, 2) != 0);
        prod[i]  = $urandom;
      end
      if (c == 300) do_reset();
      else cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
